// File: rtl/aes_ctr_seq.sv
// aes_ctr_seq: AES-CTR block sequencer driving an external aes_encrypt core
module aes_ctr_seq #(
  parameter int CTR_W = 32
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         start,
  input  logic [127:0] iv,
  input  logic [15:0]  num_blocks,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         aes_load,
  output logic [127:0] aes_pt,
  input  logic         aes_ct_valid,
  input  logic [127:0] aes_ct,
  output logic         busy,
  output logic         done
);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, COMBINE, OUT} state_t;
  localparam logic [127:0] CTR_MASK = (CTR_W >= 128) ? {128{1'b1}} : ((128'd1 << CTR_W) - 128'd1);
  state_t       state_q, state_d;
  logic [127:0] ctr_q, ctr_d, pt_q, pt_d, ks_q, ks_d, out_q, out_d;
  logic [15:0]  rem_q, rem_d;
  logic         done_q, done_d, ctv_q, ct_edge;
  assign ct_edge   = aes_ct_valid & ~ctv_q;
  assign in_ready  = state_q == COMBINE;
  assign out_valid = state_q == OUT;
  assign aes_load  = state_q == LOAD;
  assign busy      = state_q != IDLE;
  assign done      = done_q;
  assign aes_pt    = pt_q;
  assign out_data  = out_q;
  // next-state and datapath; aes_pt is a separate copy so it stays put while ctr advances
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    pt_d    = pt_q;
    ks_d    = ks_q;
    out_d   = out_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (num_blocks != 16'd0) begin
          ctr_d   = iv;
          pt_d    = iv;
          rem_d   = num_blocks;
          state_d = LOAD;
        end else done_d = 1'b1;
      end
      LOAD: state_d = WAIT;
      WAIT: if (ct_edge) begin
        ks_d    = aes_ct;
        ctr_d   = (ctr_q & ~CTR_MASK) | ((ctr_q + 128'd1) & CTR_MASK);
        state_d = COMBINE;
      end
      COMBINE: if (in_valid) begin
        out_d   = in_data ^ ks_q;
        state_d = OUT;
      end
      OUT: if (out_ready) begin
        rem_d   = rem_q - 16'd1;
        done_d  = rem_q == 16'd1;
        pt_d    = rem_q == 16'd1 ? pt_q : ctr_q;
        state_d = rem_q == 16'd1 ? IDLE : LOAD;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; the ct_valid edge history updates every cycle regardless of state
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      pt_q    <= '0;
      ks_q    <= '0;
      out_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      ctv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      pt_q    <= pt_d;
      ks_q    <= ks_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      ctv_q   <= aes_ct_valid;
    end
  end
endmodule

// File: tb/tb_aes_ctr_seq.sv
// tb_aes_ctr_seq: scoreboard bench for aes_ctr_seq with a stand-in keystream source
module tb_aes_ctr_seq;
  localparam logic [127:0] KAT_PT = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] KAT_CT = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  logic         clk = 0, rst_b = 0, start = 0, in_valid = 0, out_ready = 0, aes_ct_valid = 0;
  logic [127:0] iv = '0, in_data = '0, aes_ct = '0;
  logic [15:0]  num_blocks = '0;
  logic         in_ready, out_valid, aes_load, busy, done;
  logic [127:0] out_data, aes_pt;
  logic [127:0] pt_q[$], exp_q[$];
  int n_tests = 0, n_fail = 0, done_cnt = 0, load_cnt = 0;

  aes_ctr_seq #(.CTR_W(32)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .iv(iv), .num_blocks(num_blocks),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .aes_load(aes_load), .aes_pt(aes_pt), .aes_ct_valid(aes_ct_valid), .aes_ct(aes_ct),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (aes_load) load_cnt++;
  end

  // stand-in for aes_encrypt: the FIPS-197 vector for the known block, a fixed mix otherwise
  function automatic logic [127:0] ks_model(input logic [127:0] pt);
    if (pt == KAT_PT) return KAT_CT;
    return {pt[63:0], pt[127:64]} ^ 128'h5a5a_0f0f_3c3c_a5a5_9669_c3c3_f0f0_1234;
  endfunction

  function automatic logic [127:0] next_ctr(input logic [127:0] c);
    return {c[127:32], c[31:0] + 32'd1};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_run(input logic [127:0] v, input logic [15:0] n);
    logic [127:0] c = v;
    for (int k = 0; k < n; k++) begin
      pt_q.push_back(c);
      c = next_ctr(c);
    end
    start = 1; iv = v; num_blocks = n;
    tick();
    start = 0;
  endtask

  task automatic do_block(input logic [127:0] din, input int lat, input int stall,
                          input bit spur, input bit poke, input bit last);
    logic [127:0] cur, exp;
    for (int k = 0; k < 4 && !aes_load; k++) tick();
    n_tests++;
    if (aes_load !== 1'b1 || pt_q.size() == 0) begin
      n_fail++;
      $display("FAIL load_wait: aes_load=%b queued=%0d", aes_load, pt_q.size());
      return;
    end
    cur = pt_q.pop_front();
    n_tests++;
    if (aes_pt !== cur) begin n_fail++; $display("FAIL aes_pt: got %h want %h", aes_pt, cur); end
    aes_ct_valid = 0;
    tick();
    n_tests++;
    if (aes_load !== 1'b0) begin n_fail++; $display("FAIL load_pulse: got %b want 0", aes_load); end
    if (poke) begin start = 1; iv = ~iv; num_blocks = 16'd7; end
    repeat (lat) tick();
    start = 0;
    n_tests++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL wait_state: in_ready=%b busy=%b want 0/1", in_ready, busy);
    end
    aes_ct_valid = 1; aes_ct = ks_model(cur);
    tick();
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL in_ready: got %b want 1", in_ready); end
    if (spur) begin
      aes_ct_valid = 0;
      tick();
      aes_ct_valid = 1; aes_ct = ~aes_ct;
      tick();
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL spur_ready: got %b want 1", in_ready); end
    end
    aes_ct_valid = 0; in_valid = 1; in_data = din;
    exp_q.push_back(din ^ ks_model(cur));
    tick();
    in_valid = 0;
    exp = exp_q.pop_front();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL out: valid=%b ready=%b data %h want %h", out_valid, in_ready, out_data, exp);
    end
    for (int s = 0; s < stall; s++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== exp || aes_load !== 1'b0) begin
        n_fail++; $display("FAIL stall%0d: valid=%b load=%b data %h want %h", s, out_valid, aes_load, out_data, exp);
      end
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    n_tests++;
    if (last && (done !== 1'b1 || busy !== 1'b0)) begin
      n_fail++; $display("FAIL run_end: done=%b busy=%b want 1/0", done, busy);
    end else if (!last && (aes_load !== 1'b1 || done !== 1'b0)) begin
      n_fail++; $display("FAIL next_load: load=%b done=%b want 1/0", aes_load, done);
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    n_tests++;
    if ({aes_load, in_ready, out_valid, busy, done} !== 5'b0 || out_data !== '0 || aes_pt !== '0) begin
      n_fail++; $display("FAIL reset: ctl=%b out %h pt %h want 0", {aes_load, in_ready, out_valid, busy, done}, out_data, aes_pt);
    end
    rst_b = 1;
    tick();
  endtask

  task automatic test_kat();
    int d0 = done_cnt;
    start_run(KAT_PT, 16'd1);
    do_block('0, 3, 0, 0, 0, 1);
    tick();
    n_tests++;
    if (done_cnt !== d0 + 1 || done !== 1'b0) begin
      n_fail++; $display("FAIL kat_done: pulses %0d want %0d", done_cnt - d0, 1);
    end
  endtask

  task automatic test_zero_blocks();
    int l0 = load_cnt;
    start_run(rnd128(), 16'd0);
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_done: done=%b busy=%b want 1/0", done, busy); end
    tick();
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL zero_pulse: done=%b want 0", done); end
    repeat (3) tick();
    n_tests++;
    if (load_cnt !== l0 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_load: loads %0d busy=%b want 0/0", load_cnt - l0, busy); end
  endtask

  task automatic test_wrap();
    start_run(128'h0000_0000_0000_0000_0000_0000_ffff_ffff, 16'd2);
    do_block(rnd128(), 1, 0, 0, 0, 0);
    n_tests++;
    if (aes_pt !== '0) begin n_fail++; $display("FAIL wrap_pt: got %h want 0", aes_pt); end
    do_block(rnd128(), 2, 0, 0, 0, 1);
  endtask

  task automatic test_stall();
    start_run(rnd128(), 16'd1);
    do_block(rnd128(), 2, 10, 0, 0, 1);
  endtask

  task automatic test_reset_mid();
    int d0;
    start_run(128'h0123_4567_89ab_cdef_0011_2233_4455_6677, 16'd2);
    tick(); tick();
    rst_b = 0;
    #1;
    n_tests++;
    if ({aes_load, in_ready, out_valid, busy, done} !== 5'b0 || out_data !== '0 || aes_pt !== '0) begin
      n_fail++; $display("FAIL mid_reset: ctl=%b out %h pt %h want 0", {aes_load, in_ready, out_valid, busy, done}, out_data, aes_pt);
    end
    pt_q.delete();
    d0 = done_cnt;
    tick(); tick();
    rst_b = 1;
    tick(); tick();
    n_tests++;
    if (done_cnt !== d0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_abort: pulses %0d busy=%b want 0/0", done_cnt - d0, busy); end
    test_kat();
  endtask

  task automatic test_start_ignored();
    int d0 = done_cnt;
    start_run(128'hdead_beef_cafe_f00d_1357_9bdf_0246_8ace, 16'd2);
    do_block(rnd128(), 2, 0, 0, 1, 0);
    do_block(rnd128(), 1, 0, 0, 0, 1);
    tick(); tick();
    n_tests++;
    if (done_cnt !== d0 + 1 || busy !== 1'b0) begin n_fail++; $display("FAIL ignore_run: pulses %0d busy=%b want 1/0", done_cnt - d0, busy); end
  endtask

  task automatic test_back_to_back();
    start_run(128'h8000_0000_ffff_0000_1234_5678_ffff_fffe, 16'd3);
    do_block(rnd128(), 1, 0, 0, 0, 0);
    do_block(rnd128(), 4, 1, 1, 0, 0);
    do_block(rnd128(), 2, 0, 0, 0, 1);
    start_run(rnd128(), 16'd1);
    do_block(rnd128(), 1, 0, 0, 0, 1);
    tick();
  endtask

  initial begin
    test_reset();
    test_kat();
    test_zero_blocks();
    test_wrap();
    test_stall();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
